// File: rtl/parity_stream_gen_chk_pkg.sv
// Shared constants for the parity stream generator/checker.
// The odd_mode input is compared against these, so the encoding lives in one place.
package parity_stream_gen_chk_pkg;

    localparam logic PAR_EVEN = 1'b0;
    localparam logic PAR_ODD  = 1'b1;

endpackage

// File: rtl/pipe_reg_vr.sv
// Single-stage valid/ready pipeline register with full throughput.
// in_ready_o looks combinationally at out_ready_i so a full stage can drain and refill each cycle.
module pipe_reg_vr #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [WIDTH-1:0] in_data_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [WIDTH-1:0] out_data_o
);

    logic             valid_q, valid_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic             accept;

    always_comb begin
        in_ready_o = ~valid_q | out_ready_i;
        accept     = in_valid_i & in_ready_o;
        valid_d    = accept | (valid_q & ~out_ready_i);
        data_d     = accept ? in_data_i : data_q;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end

    assign out_valid_o = valid_q;
    assign out_data_o  = data_q;

endmodule

// File: rtl/parity_stream_gen_chk.sv
// Pipelined parity generator and checker on independent valid/ready streams,
// with a saturating error counter and sticky error flag on the check side.
module parity_stream_gen_chk
    import parity_stream_gen_chk_pkg::*;
#(
    parameter int unsigned DATA_W    = 8,
    parameter int unsigned ERR_CNT_W = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 odd_mode,
    input  logic [DATA_W-1:0]    gen_in_data,
    input  logic                 gen_in_valid,
    output logic                 gen_in_ready,
    output logic [DATA_W:0]      gen_out_data,
    output logic                 gen_out_valid,
    input  logic                 gen_out_ready,
    input  logic [DATA_W:0]      chk_in_data,
    input  logic                 chk_in_valid,
    output logic                 chk_in_ready,
    output logic [DATA_W-1:0]    chk_out_data,
    output logic                 chk_out_err,
    output logic                 chk_out_valid,
    input  logic                 chk_out_ready,
    output logic                 err_sticky,
    output logic [ERR_CNT_W-1:0] err_count,
    input  logic                 err_clr
);

    logic                 odd_sel;
    logic                 gen_par;
    logic                 chk_err;
    logic                 chk_accept;
    logic [DATA_W:0]      gen_word;
    logic [DATA_W:0]      chk_word;
    logic [DATA_W:0]      chk_reg;
    logic                 err_sticky_q, err_sticky_d;
    logic [ERR_CNT_W-1:0] err_count_q, err_count_d;

    always_comb begin
        odd_sel  = (odd_mode == PAR_ODD);
        gen_par  = (^gen_in_data) ^ odd_sel;
        chk_err  = (^chk_in_data) ^ odd_sel;
        gen_word = {gen_par, gen_in_data};
        chk_word = {chk_err, chk_in_data[DATA_W-1:0]};
    end

    pipe_reg_vr #(
        .WIDTH(DATA_W + 1)
    ) u_gen_reg (
        .clk_i      (clk),
        .rst_i      (rst),
        .in_valid_i (gen_in_valid),
        .in_ready_o (gen_in_ready),
        .in_data_i  (gen_word),
        .out_valid_o(gen_out_valid),
        .out_ready_i(gen_out_ready),
        .out_data_o (gen_out_data)
    );

    pipe_reg_vr #(
        .WIDTH(DATA_W + 1)
    ) u_chk_reg (
        .clk_i      (clk),
        .rst_i      (rst),
        .in_valid_i (chk_in_valid),
        .in_ready_o (chk_in_ready),
        .in_data_i  (chk_word),
        .out_valid_o(chk_out_valid),
        .out_ready_i(chk_out_ready),
        .out_data_o (chk_reg)
    );

    assign chk_out_data = chk_reg[DATA_W-1:0];
    assign chk_out_err  = chk_reg[DATA_W];
    assign chk_accept   = chk_in_valid & chk_in_ready;

    // Clear first, then count, so a clear coinciding with an errored accept leaves 1.
    always_comb begin
        err_sticky_d = err_sticky_q;
        err_count_d  = err_count_q;
        if (err_clr) begin
            err_sticky_d = 1'b0;
            err_count_d  = '0;
        end
        if (chk_accept && chk_err) begin
            err_sticky_d = 1'b1;
            if (err_count_d != {ERR_CNT_W{1'b1}}) begin
                err_count_d = err_count_d + ERR_CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            err_sticky_q <= 1'b0;
            err_count_q  <= '0;
        end else begin
            err_sticky_q <= err_sticky_d;
            err_count_q  <= err_count_d;
        end
    end

    assign err_sticky = err_sticky_q;
    assign err_count  = err_count_q;

endmodule

// File: tb/tb_parity_stream_gen_chk.sv
// Scoreboard bench: expected codewords/results queued at acceptance, popped by a monitor.
// Reference model uses $countones and a one-deep queue per path.
module tb_parity_stream_gen_chk;

    localparam int unsigned DATA_W    = 8;
    localparam int unsigned ERR_CNT_W = 2;
    localparam int          CNT_MAX   = (1 << ERR_CNT_W) - 1;

    logic                 clk = 1'b0;
    logic                 rst;
    logic                 odd_mode;
    logic [DATA_W-1:0]    gen_in_data;
    logic                 gen_in_valid;
    logic                 gen_in_ready;
    logic [DATA_W:0]      gen_out_data;
    logic                 gen_out_valid;
    logic                 gen_out_ready;
    logic [DATA_W:0]      chk_in_data;
    logic                 chk_in_valid;
    logic                 chk_in_ready;
    logic [DATA_W-1:0]    chk_out_data;
    logic                 chk_out_err;
    logic                 chk_out_valid;
    logic                 chk_out_ready;
    logic                 err_sticky;
    logic [ERR_CNT_W-1:0] err_count;
    logic                 err_clr;

    parity_stream_gen_chk #(
        .DATA_W   (DATA_W),
        .ERR_CNT_W(ERR_CNT_W)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .odd_mode     (odd_mode),
        .gen_in_data  (gen_in_data),
        .gen_in_valid (gen_in_valid),
        .gen_in_ready (gen_in_ready),
        .gen_out_data (gen_out_data),
        .gen_out_valid(gen_out_valid),
        .gen_out_ready(gen_out_ready),
        .chk_in_data  (chk_in_data),
        .chk_in_valid (chk_in_valid),
        .chk_in_ready (chk_in_ready),
        .chk_out_data (chk_out_data),
        .chk_out_err  (chk_out_err),
        .chk_out_valid(chk_out_valid),
        .chk_out_ready(chk_out_ready),
        .err_sticky   (err_sticky),
        .err_count    (err_count),
        .err_clr      (err_clr)
    );

    always #5 clk = ~clk;

    int n_cmp  = 0;
    int n_fail = 0;
    bit mon_en = 1'b0;

    logic [DATA_W:0] gen_q[$];
    logic [DATA_W:0] chk_q[$];
    int              m_cnt    = 0;
    bit              m_sticky = 1'b0;

    task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic par_of(input logic [DATA_W:0] w, input logic odd);
        return logic'(($countones(w) % 2) != 0) ^ odd;
    endfunction

    // Monitor: state seen at negedge is the state that will transfer on the next posedge.
    always @(negedge clk) begin
        if (mon_en) begin
            cmp("gen_in_ready", 32'(gen_in_ready), 32'((gen_q.size() == 0) || gen_out_ready));
            cmp("gen_out_valid", 32'(gen_out_valid), 32'(gen_q.size() != 0));
            if (gen_q.size() != 0) begin
                cmp("gen_out_data", 32'(gen_out_data), 32'(gen_q[0]));
                if (gen_out_ready) void'(gen_q.pop_front());
            end
            cmp("chk_in_ready", 32'(chk_in_ready), 32'((chk_q.size() == 0) || chk_out_ready));
            cmp("chk_out_valid", 32'(chk_out_valid), 32'(chk_q.size() != 0));
            if (chk_q.size() != 0) begin
                cmp("chk_out", 32'({chk_out_err, chk_out_data}), 32'(chk_q[0]));
                if (chk_out_ready) void'(chk_q.pop_front());
            end
            cmp("err_count", 32'(err_count), 32'(m_cnt));
            cmp("err_sticky", 32'(err_sticky), 32'(m_sticky));
        end
    end

    // Expected-response issue: after the monitor popped, a path accepts iff its slot is free.
    always @(negedge clk) begin
        logic e;
        #1;
        if (rst) begin
            gen_q.delete();
            chk_q.delete();
            m_cnt    = 0;
            m_sticky = 1'b0;
        end else begin
            if (gen_in_valid && gen_q.size() == 0) begin
                gen_q.push_back({par_of({1'b0, gen_in_data}, odd_mode), gen_in_data});
            end
            e = par_of(chk_in_data, odd_mode);
            if (err_clr) begin
                m_cnt    = 0;
                m_sticky = 1'b0;
            end
            if (chk_in_valid && chk_q.size() == 0) begin
                chk_q.push_back({e, chk_in_data[DATA_W-1:0]});
                if (e) begin
                    m_sticky = 1'b1;
                    if (m_cnt < CNT_MAX) m_cnt++;
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "timeout");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; odd_mode = 1'b0; err_clr = 1'b0;
        gen_in_data = '0; gen_in_valid = 1'b0; gen_out_ready = 1'b1;
        chk_in_data = '0; chk_in_valid = 1'b0; chk_out_ready = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        cmp("rst_gen_valid", 32'(gen_out_valid), 0);
        cmp("rst_chk_valid", 32'(chk_out_valid), 0);
        cmp("rst_gen_data", 32'(gen_out_data), 0);
        cmp("rst_chk_data", 32'({chk_out_err, chk_out_data}), 0);
        cmp("rst_count", 32'(err_count), 0);
        cmp("rst_sticky", 32'(err_sticky), 0);
        mon_en = 1'b1;

        // Even / odd generation, mode switching between back-to-back words.
        gen_in_valid = 1'b1; gen_in_data = 8'hA5; odd_mode = 1'b0;
        tick();
        cmp("even_a5_valid", 32'(gen_out_valid), 1);
        cmp("even_a5", 32'(gen_out_data), 32'h0A5);
        gen_in_data = 8'h07;
        tick();
        cmp("even_07", 32'(gen_out_data), 32'h107);
        gen_in_data = 8'hA5; odd_mode = 1'b1;
        tick();
        cmp("odd_a5", 32'(gen_out_data), 32'h1A5);
        gen_in_data = 8'h03; odd_mode = 1'b0;
        tick();
        cmp("switch_even_03", 32'(gen_out_data), 32'h003);
        odd_mode = 1'b1;
        tick();
        cmp("switch_odd_03", 32'(gen_out_data), 32'h103);
        gen_in_valid = 1'b0; odd_mode = 1'b0;

        // Checker: clean then errored codeword.
        chk_in_valid = 1'b1; chk_in_data = 9'h0A5;
        tick();
        cmp("chk_clean", 32'({chk_out_err, chk_out_data}), 32'h0A5);
        cmp("chk_clean_cnt", 32'(err_count), 0);
        chk_in_data = 9'h1A5;
        tick();
        cmp("chk_err", 32'({chk_out_err, chk_out_data}), 32'h1A5);
        cmp("chk_err_cnt", 32'(err_count), 1);
        cmp("chk_err_sticky", 32'(err_sticky), 1);
        chk_in_valid = 1'b0;

        // Backpressure on the generate path.
        gen_in_valid = 1'b1; gen_in_data = 8'h11; gen_out_ready = 1'b0;
        tick();
        gen_in_data = 8'h22;
        for (int i = 0; i < 3; i++) begin
            cmp("bp_ready_low", 32'(gen_in_ready), 0);
            cmp("bp_hold", 32'(gen_out_data), 32'h011);
            tick();
        end
        gen_out_ready = 1'b1;
        tick();
        cmp("bp_resume_22", 32'(gen_out_data), 32'h022);
        gen_in_data = 8'h33;
        tick();
        cmp("bp_resume_33", 32'(gen_out_data), 32'h033);
        gen_in_valid = 1'b0;

        // Saturation and clear.
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0; chk_in_valid = 1'b1; chk_in_data = 9'h1A5;
        repeat (5) tick();
        cmp("sat_count", 32'(err_count), 3);
        cmp("sat_sticky", 32'(err_sticky), 1);
        chk_in_valid = 1'b0; err_clr = 1'b1;
        tick();
        cmp("clr_count", 32'(err_count), 0);
        cmp("clr_sticky", 32'(err_sticky), 0);
        chk_in_valid = 1'b1;
        tick();
        cmp("clr_err_count", 32'(err_count), 1);
        cmp("clr_err_sticky", 32'(err_sticky), 1);
        err_clr = 1'b0;
        tick();
        cmp("pre_rst_count", 32'(err_count), 2);
        chk_in_valid = 1'b0;

        // Reset mid-stream with a stalled codeword.
        gen_out_ready = 1'b0; gen_in_valid = 1'b1; gen_in_data = 8'h55;
        tick();
        cmp("pre_rst_valid", 32'(gen_out_valid), 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        cmp("mid_rst_gen_valid", 32'(gen_out_valid), 0);
        cmp("mid_rst_chk_valid", 32'(chk_out_valid), 0);
        cmp("mid_rst_gen_data", 32'(gen_out_data), 0);
        cmp("mid_rst_count", 32'(err_count), 0);
        cmp("mid_rst_sticky", 32'(err_sticky), 0);
        gen_out_ready = 1'b1;
        tick();
        cmp("post_rst_valid", 32'(gen_out_valid), 1);
        cmp("post_rst_data", 32'(gen_out_data), 32'h055);
        gen_in_valid = 1'b0;

        // Randomized traffic on both paths at once.
        for (int i = 0; i < 600; i++) begin
            tick();
            gen_in_valid  = ($urandom_range(0, 3) != 0);
            gen_in_data   = DATA_W'($urandom);
            chk_in_valid  = ($urandom_range(0, 3) != 0);
            chk_in_data   = (DATA_W + 1)'($urandom);
            odd_mode      = 1'($urandom);
            gen_out_ready = ($urandom_range(0, 9) < 7);
            chk_out_ready = ($urandom_range(0, 9) < 7);
            err_clr       = ($urandom_range(0, 19) == 0);
        end

        tick();
        gen_in_valid = 1'b0; chk_in_valid = 1'b0; err_clr = 1'b0;
        gen_out_ready = 1'b1; chk_out_ready = 1'b1;
        for (int i = 0; i < 10 && (gen_q.size() != 0 || chk_q.size() != 0); i++) tick();
        tick();
        cmp("drain_gen", 32'(gen_q.size()), 0);
        cmp("drain_chk", 32'(chk_q.size()), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/parity_stream_gen_chk.md
Name: parity_stream_gen_chk

Overview:
- Parametrised, pipelined successor to the team's combinational parity generator/checker.
- Generate path: takes DATA_W-bit words on a valid/ready stream and emits each word with one appended parity bit.
- Check path: takes (DATA_W+1)-bit codewords, flags parity errors per word, and keeps a saturating error counter plus a sticky error flag.
- Sits between a data source and a link/storage interface; even/odd mode is runtime-selectable.

Parameters:
- DATA_W, 8, payload width in bits (>=1).
- ERR_CNT_W, 8, width of saturating error counter (>=1).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- odd_mode  in  1  0 = even parity, 1 = odd parity; sampled per word at acceptance.
- gen_in_data  in  DATA_W  payload to protect.
- gen_in_valid  in  1  payload valid.
- gen_in_ready  out  1  generator can accept.
- gen_out_data  out  DATA_W+1  {parity, payload}; parity is the MSB.
- gen_out_valid  out  1  codeword valid.
- gen_out_ready  in  1  downstream accepts.
- chk_in_data  in  DATA_W+1  codeword to check; MSB is the parity bit.
- chk_in_valid  in  1  codeword valid.
- chk_in_ready  out  1  checker can accept.
- chk_out_data  out  DATA_W  payload with parity stripped.
- chk_out_err  out  1  parity error for this word.
- chk_out_valid  out  1  result valid.
- chk_out_ready  in  1  downstream accepts.
- err_sticky  out  1  set on any checked error; holds until cleared.
- err_count  out  ERR_CNT_W  number of errored words, saturating at all-ones.
- err_clr  in  1  synchronous clear of err_sticky and err_count.

Behaviour:
- Reset (rst=1 at a clk edge):
  - all *_valid = 0, err_sticky = 0, err_count = 0;
  - gen_out_data, chk_out_data and chk_out_err = 0.
- Reset mid-transfer drops the in-flight word; no partial output is produced.
- Each path is one pipeline register, so latency is 1 cycle from acceptance to *_out_valid.
- Handshake, per path:
  - in_ready = ~out_valid | out_ready.
  - Accept when in_valid & in_ready. On accept, out_valid = 1 next cycle and the register loads.
  - If out_valid & out_ready and no new accept, out_valid = 0 next cycle.
  - Out data is held stable while out_valid & ~out_ready.
  - Full throughput: one word per cycle when out_ready = 1.
  - in_ready depends combinationally on out_ready; there is no other combinational in-to-out path.
- Generate: parity = (^gen_in_data) ^ odd_mode. The full DATA_W+1 codeword therefore has even (odd) weight in even (odd) mode.
- Check: err = (^chk_in_data) ^ odd_mode, computed at acceptance and registered with the payload.
- odd_mode change takes effect on the next accepted word; words already in a register keep their result.
- Error accounting happens at chk acceptance of a word with err = 1, not at output:
  - err_sticky <= 1;
  - err_count <= err_count + 1, unless already all-ones (saturate, no wrap).
- err_clr:
  - err_clr alone: sticky = 0, count = 0 next cycle.
  - err_clr and an errored accept in the same cycle: the clear applies first, then the new error is counted, giving sticky = 1, count = 1.
- The two paths are independent. Simultaneous activity on both is legal and neither path stalls the other.

Decomposition:
- Shared package/header holds parity mode constants (PAR_EVEN = 0, PAR_ODD = 1).
- One sub-module is natural: pipe_reg_vr, a parametrised (WIDTH) single-stage valid/ready register, instantiated twice (gen width DATA_W+1, chk width DATA_W+1 including err).
- Parity reduction stays inline.

Test Plan (DATA_W=8):
- Even gen: gen_in_data = 8'hA5 (4 ones), odd_mode = 0 -> next cycle gen_out_data = 9'h0A5, valid = 1. Then 8'h07 -> 9'h107.
- Odd gen: odd_mode = 1, 8'hA5 -> 9'h1A5. Switch odd_mode between back-to-back words -> each word uses the mode sampled at its own acceptance.
- Check:
  - odd_mode = 0, codeword 9'h0A5 -> chk_out_data = 8'hA5, err = 0, count stays 0.
  - 9'h1A5 -> err = 1, err_sticky = 1, err_count = 1.
- Backpressure: gen_out_ready = 0 for 3 cycles with gen_in_valid = 1 -> gen_in_ready = 0, gen_out_data stable, no words lost or duplicated. Release -> stream resumes at 1 word/cycle in order.
- Saturation and clear, with ERR_CNT_W = 2:
  - 5 errored words -> err_count = 3.
  - err_clr alone -> 0/0.
  - err_clr in the same cycle as an errored accept -> count = 1, sticky = 1.
- Reset mid-stream: assert rst while gen_out_valid = 1 and count = 2 -> next cycle all valids = 0, count = 0, sticky = 0. The first post-reset word has 1-cycle latency.
